lcd_hex_driver: RTL and testbench

Write-only HD44780 character-LCD controller that shows two 64-bit values as hexadecimal on a 16x2 display: `a` on line 1, `b` on line 2, 16 digits each, MSB first. It sits directly downstream of the board top level, consuming the `lcd_a`/`lcd_b` debug buses and driving the LCD pins on GPIO_1 over an 8-bit bus. After power-up initialisation it refreshes both lines in an endless loop, with no handshake toward the producer.

---
 rtl/lcd_hex_driver.sv | 184 ++++++++++++++++++
 tb/tb_lcd_hex_driver.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_hex_driver.sv
// ---------------------------------------------------------------------------
// lcd_hex_driver
//
// Write-only HD44780 controller for a 16x2 character LCD on an 8-bit bus.
// After power-up it runs the standard init sequence. It then refreshes the
// display forever: line 1 shows `a` and line 2 shows `b`, each as 16
// uppercase hex digits with the MSB first. There is no handshake toward the
// producer. Each line's value is snapshotted when that line's cursor command
// is issued, so a line never shows a mix of old and new input values.
//
// Ports
//   clk        in   system clock
//   reset      in   asynchronous, active-low reset
//   a          in   64-bit value shown on line 1
//   b          in   64-bit value shown on line 2
//   LCD_RS     out  0 = command, 1 = data
//   LCD_E      out  enable strobe (the LCD latches on the falling edge)
//   LCD_D      out  8-bit data bus (RW is tied low on the board)
//   init_done  out  high once initialisation has finished
//   frame_done out  one-cycle pulse per completed two-line refresh
// ---------------------------------------------------------------------------
module lcd_hex_driver #(
    parameter int T_POWERUP = 1_000_000,  // power-on wait before the first command
    parameter int T_EPULSE  = 25,         // E high time per write
    parameter int T_CMD     = 2500,       // wait after a normal write
    parameter int T_CLEAR   = 100_000     // wait after the first function set and after clear
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic        LCD_RS,
    output logic        LCD_E,
    output logic [7:0]  LCD_D,
    output logic        init_done,
    output logic        frame_done
);

    localparam int MAX_AB = (T_POWERUP > T_EPULSE) ? T_POWERUP : T_EPULSE;
    localparam int MAX_CD = (T_CMD > T_CLEAR) ? T_CMD : T_CLEAR;
    localparam int MAX_T  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW     = $clog2(MAX_T + 1);

    typedef enum logic [1:0] {
        ST_POWER,
        ST_SETUP,
        ST_PULSE,
        ST_WAIT
    } state_t;

    // One hex digit as an uppercase ASCII character. The shift amount
    // 4*(15-k) equals {~k, 2'b00} for a 4-bit k, so digit 0 is the top nibble.
    function automatic logic [7:0] hex_char(input logic [63:0] sh, input logic [3:0] k);
        logic [3:0] n;
        n = 4'(sh >> {~k, 2'b00});
        return (n <= 4'd9) ? {4'h3, n} : (8'h37 + {4'h0, n});
    endfunction

    // {RS, D} for a given step of the init or refresh sequence.
    function automatic logic [8:0] step_word(input logic        init,
                                             input logic [5:0]  idx,
                                             input logic [63:0] sh_a,
                                             input logic [63:0] sh_b);
        logic [5:0] k;
        k = 6'd0;
        if (init) begin
            case (idx)
                6'd0, 6'd1, 6'd2: return {1'b0, 8'h38};  // function set: 8-bit, 2 lines
                6'd3:             return {1'b0, 8'h0C};  // display on, cursor off
                6'd4:             return {1'b0, 8'h06};  // entry mode: increment
                default:          return {1'b0, 8'h01};  // clear display
            endcase
        end else if (idx == 6'd0) begin
            return {1'b0, 8'h80};                        // cursor to line 1
        end else if (idx == 6'd17) begin
            return {1'b0, 8'hC0};                        // cursor to line 2
        end else if (idx < 6'd17) begin
            k = idx - 6'd1;
            return {1'b1, hex_char(sh_a, k[3:0])};
        end else begin
            k = idx - 6'd18;
            return {1'b1, hex_char(sh_b, k[3:0])};
        end
    endfunction

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_init_phase;  // 1 while the init sequence is running
    logic [5:0]    r_idx;         // init step 0..5, or refresh step 0..33
    logic [63:0]   r_sh_a;
    logic [63:0]   r_sh_b;

    logic          w_nxt_init;
    logic [5:0]    w_nxt_idx;
    logic [8:0]    w_nxt_word;
    logic [CW-1:0] w_wait;
    logic          w_frame_start;

    // Step sequencing and the wait length of the step currently on the bus.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        w_nxt_init = r_init_phase;
        w_nxt_idx  = r_idx + 6'd1;
        if (r_init_phase && r_idx == 6'd5) begin
            w_nxt_init = 1'b0;
            w_nxt_idx  = 6'd0;
        end else if (!r_init_phase && r_idx == 6'd33) begin
            w_nxt_idx = 6'd0;
        end
        w_nxt_word    = step_word(w_nxt_init, w_nxt_idx, r_sh_a, r_sh_b);
        w_frame_start = !w_nxt_init && (w_nxt_idx == 6'd0);
        w_wait        = (r_init_phase && (r_idx == 6'd0 || r_idx == 6'd5))
                        ? CW'(T_CLEAR - 1) : CW'(T_CMD - 1);
    end

    // Write engine. Every phase length is loaded as (cycles - 1) and counted
    // down to zero. POWER is loaded with T_POWERUP at reset, so the first
    // SETUP lands exactly T_POWERUP edges after reset is released.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_POWER;
            r_cnt        <= CW'(T_POWERUP);
            r_init_phase <= 1'b1;
            r_idx        <= 6'd0;
            r_sh_a       <= '0;
            r_sh_b       <= '0;
            LCD_RS       <= 1'b0;
            LCD_E        <= 1'b0;
            LCD_D        <= 8'h00;
            init_done    <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // read in this block sees the value from before the clock edge.
            frame_done <= 1'b0;
            case (r_state)
                ST_POWER: begin
                    if (r_cnt == '0) begin
                        r_state         <= ST_SETUP;
                        {LCD_RS, LCD_D} <= step_word(1'b1, 6'd0, r_sh_a, r_sh_b);
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_SETUP: begin
                    r_state <= ST_PULSE;
                    LCD_E   <= 1'b1;
                    r_cnt   <= CW'(T_EPULSE - 1);
                end
                ST_PULSE: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_WAIT;
                        LCD_E   <= 1'b0;
                        r_cnt   <= w_wait;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state         <= ST_SETUP;
                        r_init_phase    <= w_nxt_init;
                        r_idx           <= w_nxt_idx;
                        {LCD_RS, LCD_D} <= w_nxt_word;
                        if (w_frame_start) begin
                            r_sh_a     <= a;
                            init_done  <= 1'b1;
                            // The old init_done value is still 0 on the first
                            // step 0 after init, so that step gets no pulse.
                            frame_done <= init_done;
                        end
                        if (!w_nxt_init && w_nxt_idx == 6'd17) begin
                            r_sh_b <= b;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= ST_POWER;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_hex_driver.sv
// ---------------------------------------------------------------------------
// tb_lcd_hex_driver
//
// Self-checking bench for lcd_hex_driver using short timing parameters.
// Expected bus writes are listed in tables of {RS, D, wait-after} records.
// These cover the init sequence and several refresh frames, and are compared
// write by write. Hand-written sequences cover the power-up window, the
// snapshot of line 1, the frame_done spacing and an asynchronous reset
// applied mid-pulse.
// ---------------------------------------------------------------------------
module tb_lcd_hex_driver;

    localparam int TP       = 10;
    localparam int TE       = 2;
    localparam int TC       = 4;
    localparam int TCL      = 8;
    localparam int INIT_LEN = 6 + 6 * TE + 2 * TCL + 4 * TC;  // 50
    localparam int FRAME    = 34 * (1 + TE + TC);             // 238

    typedef struct {
        logic       rs;
        logic [7:0] d;
        int         gap;   // cycles from E fall to the next SETUP
    } vec_t;
    typedef vec_t vq_t[$];

    typedef struct {
        logic       rs_su;
        logic [7:0] d_su;
        logic       rs;
        logic [7:0] d;
        int         su;
        int         fall;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic        LCD_RS;
    logic        LCD_E;
    logic [7:0]  LCD_D;
    logic        init_done;
    logic        frame_done;

    lcd_hex_driver #(
        .T_POWERUP(TP),
        .T_EPULSE (TE),
        .T_CMD    (TC),
        .T_CLEAR  (TCL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .a         (a),
        .b         (b),
        .LCD_RS    (LCD_RS),
        .LCD_E     (LCD_E),
        .LCD_D     (LCD_D),
        .init_done (init_done),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Cycle k is the clock period that follows rising edge k after release.
    int cyc;
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= -1;
        else        cyc <= cyc + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Records when init_done first rises and every frame_done pulse.
    int init_rise = -1;
    int fd_q[$];
    int fd_high = 0;
    bit mon_en = 1'b1;
    initial begin
        forever begin
            @(negedge clk);
            if (reset && mon_en) begin
                if (init_done && init_rise < 0) init_rise = cyc;
                if (frame_done) begin
                    fd_high++;
                    if (fd_q.size() == 0 || fd_q[$] != cyc - 1) fd_q.push_back(cyc);
                end
            end
        end
    end

    // Waits for the next full E pulse. Captures RS/D in the SETUP cycle
    // (the sample just before E rises) and again when E has fallen.
    task automatic next_write(output wr_t w, output bit ok);
        logic       pe;
        logic       prs;
        logic [7:0] pd;
        int         pc;
        bit         seen;
        pe = LCD_E; prs = LCD_RS; pd = LCD_D; pc = cyc;
        seen = 1'b0; ok = 1'b0;
        w = '{rs_su: 1'b0, d_su: 8'h00, rs: 1'b0, d: 8'h00, su: -1, fall: -1};
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (!seen && LCD_E && !pe) begin
                seen    = 1'b1;
                w.su    = pc;
                w.rs_su = prs;
                w.d_su  = pd;
            end else if (seen && !LCD_E) begin
                w.fall = cyc;
                w.rs   = LCD_RS;
                w.d    = LCD_D;
                ok     = 1'b1;
                break;
            end
            pe = LCD_E; prs = LCD_RS; pd = LCD_D; pc = cyc;
        end
        if (!ok) check("write_timeout", 64'd0, 64'd1);
    endtask

    int prev_fall = -1;
    int prev_gap  = 0;

    task automatic run_vecs(input vq_t v, input string tag, output int su0);
        wr_t w;
        bit  ok;
        su0 = -1;
        foreach (v[i]) begin
            next_write(w, ok);
            if (!ok) return;
            if (i == 0) su0 = w.su;
            check($sformatf("%s[%0d].rs_setup", tag, i), w.rs_su, v[i].rs);
            check($sformatf("%s[%0d].d_setup", tag, i), w.d_su, v[i].d);
            check($sformatf("%s[%0d].rs_fall", tag, i), w.rs, v[i].rs);
            check($sformatf("%s[%0d].d_fall", tag, i), w.d, v[i].d);
            check($sformatf("%s[%0d].e_width", tag, i), w.fall - w.su - 1, TE);
            if (prev_fall >= 0)
                check($sformatf("%s[%0d].gap", tag, i), w.su - prev_fall, prev_gap);
            prev_fall = w.fall;
            prev_gap  = v[i].gap;
        end
    endtask

    function automatic vq_t build_frame(input string l1, input string l2);
        vq_t q;
        q.push_back('{rs: 1'b0, d: 8'h80, gap: TC});
        for (int i = 0; i < 16; i++) q.push_back('{rs: 1'b1, d: l1[i], gap: TC});
        q.push_back('{rs: 1'b0, d: 8'hC0, gap: TC});
        for (int i = 0; i < 16; i++) q.push_back('{rs: 1'b1, d: l2[i], gap: TC});
        return q;
    endfunction

    task automatic check_power_window(input string tag);
        for (int k = 0; k < TP; k++) begin
            @(negedge clk);
            check($sformatf("%s.cycle%0d", tag, k),
                  {LCD_E, LCD_RS, LCD_D, init_done, frame_done}, 64'd0);
        end
    endtask

    vq_t init_v;
    vq_t frame_ab;
    vq_t frame2;
    vq_t frame_fb;
    int  su_f[3];
    int  su_tmp;
    bit  found;

    initial begin
        init_v = '{'{rs: 1'b0, d: 8'h38, gap: TCL},
                   '{rs: 1'b0, d: 8'h38, gap: TC},
                   '{rs: 1'b0, d: 8'h38, gap: TC},
                   '{rs: 1'b0, d: 8'h0C, gap: TC},
                   '{rs: 1'b0, d: 8'h06, gap: TC},
                   '{rs: 1'b0, d: 8'h01, gap: TCL}};
        frame_ab = build_frame("0123456789ABCDEF", "FEDCBA9876543210");
        frame_fb = build_frame("FFFFFFFFFFFFFFFF", "FEDCBA9876543210");

        a = 64'h0123_4567_89AB_CDEF;
        b = 64'hFEDC_BA98_7654_3210;

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset.E", LCD_E, 64'd0);
        check("reset.RS", LCD_RS, 64'd0);
        check("reset.D", LCD_D, 64'd0);
        check("reset.init_done", init_done, 64'd0);
        check("reset.frame_done", frame_done, 64'd0);

        // Power-up window, then the init sequence.
        reset = 1'b1;
        check_power_window("power");
        run_vecs(init_v, "init", su_tmp);
        check("init.first_setup_cycle", su_tmp, TP);

        // Frame 1, checked against the initial a and b.
        run_vecs(frame_ab, "frame1", su_f[0]);
        check("frame1.step0_cycle", su_f[0], TP + INIT_LEN);
        check("init_done.rise_cycle", init_rise, TP + INIT_LEN);

        // Frame 2: a changes after char 5 of line 1 but must not tear the line.
        frame2 = frame_ab[0:6];
        run_vecs(frame2, "frame2a", su_f[1]);
        a = '1;
        frame2 = frame_ab[7:33];
        run_vecs(frame2, "frame2b", su_tmp);

        // Frame 3 shows the new snapshot of a.
        run_vecs(frame_fb, "frame3", su_f[2]);

        // Frame rate and frame_done pulses.
        check("frame.period12", su_f[1] - su_f[0], FRAME);
        check("frame.period23", su_f[2] - su_f[1], FRAME);
        check("frame_done.count", fd_q.size(), 2);
        check("frame_done.high_cycles", fd_high, 2);
        if (fd_q.size() >= 2) begin
            check("frame_done.pulse0", fd_q[0], su_f[1]);
            check("frame_done.pulse1", fd_q[1], su_f[2]);
        end
        mon_en = 1'b0;

        // Asynchronous reset while E is high during a data write.
        found = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (LCD_E && LCD_RS) begin
                found = 1'b1;
                break;
            end
        end
        check("midreset.found_data_pulse", found, 64'd1);
        #2 reset = 1'b0;
        #1;
        check("midreset.E", LCD_E, 64'd0);
        check("midreset.RS", LCD_RS, 64'd0);
        check("midreset.D", LCD_D, 64'd0);
        check("midreset.init_done", init_done, 64'd0);
        @(negedge clk);
        check("midreset.frame_done", frame_done, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        check_power_window("repower");
        prev_fall = -1;
        frame2 = init_v[0:0];
        run_vecs(frame2, "reinit", su_tmp);
        check("reinit.first_setup_cycle", su_tmp, TP);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard stop so the run always terminates.
    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
